// File: rtl/pipe_ctrl.sv
// Pipeline sequencing for the multi-stage core: per-stage valid/payload registers,
// allowin/ready_go handshake, stall propagation and flush of younger stages.
module pipe_ctrl #(
  parameter int unsigned STAGES = 5,
  parameter int unsigned BUS_W  = 64,
  parameter int unsigned FW     = $clog2(STAGES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [BUS_W-1:0]        in_bus,
  output logic                    in_ready,
  input  logic [STAGES-1:0]       ready_go,
  output logic [STAGES-1:0]       stage_valid,
  output logic [STAGES*BUS_W-1:0] stage_bus,
  output logic [STAGES-1:0]       stage_allowin,
  output logic                    out_valid,
  output logic [BUS_W-1:0]        out_bus,
  input  logic                    out_ready,
  input  logic                    flush,
  input  logic [FW-1:0]           flush_stage,
  output logic [31:0]             retire_cnt,
  output logic [31:0]             stall_cnt
);

  localparam int unsigned L = STAGES - 1;

  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0][BUS_W-1:0] bus_q, bus_d;
  logic [STAGES-1:0]            allowin, src_valid, kill_in;
  logic [STAGES-1:0][BUS_W-1:0] src_bus;
  logic [31:0]                  retire_cnt_q, retire_cnt_d;
  logic [31:0]                  stall_cnt_q, stall_cnt_d;
  int unsigned                  f_eff;

  // allowin ripples from the oldest stage back towards stage 0.
  always_comb begin
    allowin    = '0;
    allowin[L] = !valid_q[L] | (ready_go[L] & out_ready);
    for (int unsigned k = L; k > 0; k--) begin
      allowin[k-1] = !valid_q[k-1] | (ready_go[k-1] & allowin[k]);
    end
  end

  always_comb begin
    src_valid    = '0;
    src_bus      = '0;
    src_valid[0] = in_valid;
    src_bus[0]   = in_bus;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_valid[k] = valid_q[k-1] & ready_go[k-1];
      src_bus[k]   = bus_q[k-1];
    end
  end

  // Out-of-range flush_stage saturates to the oldest stage.
  always_comb begin
    f_eff = 32'(flush_stage);
    if (f_eff > L) f_eff = L;
    kill_in = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      kill_in[k] = flush & (k <= f_eff);
    end
  end

  always_comb begin
    valid_d = valid_q;
    bus_d   = bus_q;
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (allowin[k]) begin
        valid_d[k] = src_valid[k] & !kill_in[k];
        if (src_valid[k] & !kill_in[k]) bus_d[k] = src_bus[k];
      end else if (flush && (k < f_eff)) begin
        valid_d[k] = 1'b0;
      end
    end
  end

  always_comb begin
    out_valid    = valid_q[L] & ready_go[L];
    retire_cnt_d = retire_cnt_q + 32'(out_valid & out_ready);
    stall_cnt_d  = stall_cnt_q + 32'(valid_q[L] & !(ready_go[L] & out_ready));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= '0;
      bus_q        <= '0;
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      valid_q      <= valid_d;
      bus_q        <= bus_d;
      retire_cnt_q <= retire_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign in_ready      = allowin[0];
  assign stage_allowin = allowin;
  assign stage_valid   = valid_q;
  assign stage_bus     = bus_q;
  assign out_bus       = bus_q[L];
  assign retire_cnt    = retire_cnt_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with STAGES=5, BUS_W=32.
module tb_pipe_ctrl;

  localparam int unsigned STAGES = 5;
  localparam int unsigned BUS_W  = 32;
  localparam int unsigned FW     = 3;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    in_valid;
  logic [BUS_W-1:0]        in_bus;
  logic                    in_ready;
  logic [STAGES-1:0]       ready_go;
  logic [STAGES-1:0]       stage_valid;
  logic [STAGES*BUS_W-1:0] stage_bus;
  logic [STAGES-1:0]       stage_allowin;
  logic                    out_valid;
  logic [BUS_W-1:0]        out_bus;
  logic                    out_ready;
  logic                    flush;
  logic [FW-1:0]           flush_stage;
  logic [31:0]             retire_cnt;
  logic [31:0]             stall_cnt;

  int total = 0;
  int bad   = 0;

  pipe_ctrl #(.STAGES(STAGES), .BUS_W(BUS_W), .FW(FW)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_bus        (in_bus),
    .in_ready      (in_ready),
    .ready_go      (ready_go),
    .stage_valid   (stage_valid),
    .stage_bus     (stage_bus),
    .stage_allowin (stage_allowin),
    .out_valid     (out_valid),
    .out_bus       (out_bus),
    .out_ready     (out_ready),
    .flush         (flush),
    .flush_stage   (flush_stage),
    .retire_cnt    (retire_cnt),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid    = 1'b0;
    in_bus      = '0;
    ready_go    = '1;
    out_ready   = 1'b1;
    flush       = 1'b0;
    flush_stage = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Leaves stage k holding base+k, all valid, out_ready low.
  task automatic fill(input logic [31:0] base);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_bus   = base + 32'(4 - i);
      #1;
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL fill_accept[%0d]: in_ready=%b required 1", i, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (stage_bus[k*32 +: 32] !== base + 32'(k) || stage_valid[k] !== 1'b1) begin
        bad++;
        $display("FAIL fill_stage[%0d]: bus=%h valid=%b required %h valid=1",
                 k, stage_bus[k*32 +: 32], stage_valid[k], base + 32'(k));
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if (stage_valid !== 5'b0 || stage_bus !== '0 || out_valid !== 1'b0 || out_bus !== 32'h0 ||
        retire_cnt !== 32'd0 || stall_cnt !== 32'd0 || in_ready !== 1'b1 ||
        stage_allowin !== 5'b11111) begin
      bad++;
      $display("FAIL reset_state: valid=%b bus=%h ov=%b ob=%h rc=%0d sc=%0d ir=%b al=%b required all zero, ir=1 al=11111",
               stage_valid, stage_bus, out_valid, out_bus, retire_cnt, stall_cnt, in_ready,
               stage_allowin);
    end
  endtask

  task automatic test_streaming();
    int sent = 0;
    int got = 0;
    int first_c = -1;
    logic acc;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      in_valid = (sent < 10);
      in_bus   = 32'h100 + 32'(sent);
      #1;
      if (out_valid === 1'b1) begin
        if (first_c < 0) first_c = c;
        total++;
        if (out_bus !== 32'h100 + 32'(got)) begin
          bad++;
          $display("FAIL stream_order[%0d]: out_bus=%h required %h", got, out_bus,
                   32'h100 + 32'(got));
        end
        got++;
      end
      acc = in_valid & in_ready;
      tick();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    total++;
    if (first_c !== 5) begin
      bad++;
      $display("FAIL stream_latency: first out_valid cycle=%0d required 5", first_c);
    end
    total++;
    if (got !== 10 || retire_cnt !== 32'd10) begin
      bad++;
      $display("FAIL stream_count: got=%0d retire_cnt=%0d required 10", got, retire_cnt);
    end
    total++;
    if (stall_cnt !== 32'd0) begin
      bad++;
      $display("FAIL stream_stall_cnt: stall_cnt=%0d required 0", stall_cnt);
    end
  endtask

  task automatic test_mid_stall();
    logic [31:0] exp_q[5] = '{32'h204, 32'h203, 32'h202, 32'h201, 32'h200};
    int n = 0;
    do_reset();
    fill(32'h200);
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      ready_go = (c < 3) ? 5'b11011 : 5'b11111;
      in_valid = (c < 3);
      in_bus   = 32'h2F0;
      #1;
      if (c < 3) begin
        total++;
        if (in_ready !== 1'b0 || stage_allowin !== 5'b11000) begin
          bad++;
          $display("FAIL stall_allowin[%0d]: in_ready=%b allowin=%b required 0 / 11000",
                   c, in_ready, stage_allowin);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        total++;
        if (n >= 5 || out_bus !== exp_q[n % 5]) begin
          bad++;
          $display("FAIL stall_retire[%0d]: out_bus=%h required %h", n, out_bus, exp_q[n % 5]);
        end
        n++;
      end
      tick();
      if (c < 3) begin
        total++;
        if (stage_valid[3:0] !== 4'b0111 || stage_bus[0 +: 32] !== 32'h200 ||
            stage_bus[32 +: 32] !== 32'h201 || stage_bus[64 +: 32] !== 32'h202) begin
          bad++;
          $display("FAIL stall_hold[%0d]: valid=%b bus0..2=%h %h %h required 0111 200 201 202",
                   c, stage_valid[3:0], stage_bus[0 +: 32], stage_bus[32 +: 32],
                   stage_bus[64 +: 32]);
        end
      end
    end
    in_valid = 1'b0;
    total++;
    if (n !== 5 || retire_cnt !== 32'd5 || stage_valid !== 5'b0) begin
      bad++;
      $display("FAIL stall_drain: retired=%0d retire_cnt=%0d valid=%b required 5 5 00000",
               n, retire_cnt, stage_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    fill(32'h300);
    for (int c = 0; c < 4; c++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_bus    = 32'h3FF;
      #1;
      total++;
      if (stage_allowin !== 5'b0 || in_ready !== 1'b0 || out_valid !== 1'b1 ||
          out_bus !== 32'h304) begin
        bad++;
        $display("FAIL bp_cycle[%0d]: allowin=%b in_ready=%b ov=%b ob=%h required 00000 0 1 304",
                 c, stage_allowin, in_ready, out_valid, out_bus);
      end
      tick();
    end
    in_valid = 1'b0;
    total++;
    if (stall_cnt !== 32'd4 || retire_cnt !== 32'd0) begin
      bad++;
      $display("FAIL bp_counts: stall_cnt=%0d retire_cnt=%0d required 4 0", stall_cnt, retire_cnt);
    end
  endtask

  task automatic test_flush();
    do_reset();
    fill(32'hA0);
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    in_bus      = 32'hA5;
    flush       = 1'b1;
    flush_stage = 3'd3;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_bus !== 32'hA4) begin
      bad++;
      $display("FAIL flush_pre: in_ready=%b ov=%b ob=%h required 1 1 a4", in_ready, out_valid,
               out_bus);
    end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    total++;
    if (stage_valid !== 5'b10000 || stage_bus[128 +: 32] !== 32'hA3) begin
      bad++;
      $display("FAIL flush_after: valid=%b bus4=%h required 10000 a3", stage_valid,
               stage_bus[128 +: 32]);
    end
    total++;
    if (out_valid !== 1'b1 || out_bus !== 32'hA3) begin
      bad++;
      $display("FAIL flush_retire: ov=%b ob=%h required 1 a3", out_valid, out_bus);
    end
    tick();
    for (int c = 0; c < 6; c++) begin
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL flush_leak[%0d]: out_valid=%b out_bus=%h required 0", c, out_valid,
                 out_bus);
      end
      tick();
    end
    total++;
    if (retire_cnt !== 32'd2) begin
      bad++;
      $display("FAIL flush_count: retire_cnt=%0d required 2", retire_cnt);
    end
  endtask

  task automatic test_flush_stall();
    do_reset();
    fill(32'hB0);
    out_ready   = 1'b1;
    ready_go    = 5'b11011;
    flush       = 1'b1;
    flush_stage = 3'd2;
    tick();
    #1;
    total++;
    if (stage_valid !== 5'b10100 || stage_bus[64 +: 32] !== 32'hB2 ||
        stage_bus[128 +: 32] !== 32'hB3) begin
      bad++;
      $display("FAIL flush_stall: valid=%b bus2=%h bus4=%h required 10100 b2 b3", stage_valid,
               stage_bus[64 +: 32], stage_bus[128 +: 32]);
    end
    // flush_stage beyond the last stage acts as the oldest stage, which survives.
    ready_go    = 5'b11111;
    out_ready   = 1'b0;
    flush_stage = 3'd7;
    tick();
    flush = 1'b0;
    #1;
    total++;
    if (stage_valid !== 5'b10000 || stage_bus[128 +: 32] !== 32'hB3) begin
      bad++;
      $display("FAIL flush_clamp: valid=%b bus4=%h required 10000 b3", stage_valid,
               stage_bus[128 +: 32]);
    end
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    fill(32'hC0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_bus    = 32'hC5;
    tick();
    tick();
    total++;
    if (retire_cnt !== 32'd2) begin
      bad++;
      $display("FAIL rst_pre_count: retire_cnt=%0d required 2", retire_cnt);
    end
    reset = 1'b1;
    tick();
    #1;
    total++;
    if (stage_valid !== 5'b0 || stage_bus !== '0 || out_valid !== 1'b0 || out_bus !== 32'h0 ||
        retire_cnt !== 32'd0 || stall_cnt !== 32'd0 || in_ready !== 1'b1 ||
        stage_allowin !== 5'b11111) begin
      bad++;
      $display("FAIL rst_mid: valid=%b ov=%b ob=%h rc=%0d sc=%0d ir=%b al=%b required reset values",
               stage_valid, out_valid, out_bus, retire_cnt, stall_cnt, in_ready, stage_allowin);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_streaming();
    test_mid_stall();
    test_backpressure();
    test_flush();
    test_flush_stall();
    test_reset_mid_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
